// File: rtl/conv_bias_fetch_pkg.sv
// Shared widths, FSM encoding and helpers for the conv bias fetch path.
package conv_bias_fetch_pkg;

    localparam int unsigned BM_DEPTH      = 1024;
    localparam int unsigned BM_DATA_WIDTH = 512;

    localparam int unsigned CBF_ADDR_W  = $clog2(BM_DEPTH);
    localparam int unsigned CBF_DATA_W  = BM_DATA_WIDTH;
    localparam int unsigned CBF_CNT_W   = 16;
    localparam int unsigned CBF_TOTAL_W = 32;

    typedef enum logic [1:0] {
        CBF_IDLE  = 2'd0,
        CBF_RUN   = 2'd1,
        CBF_DRAIN = 2'd2,
        CBF_DONE  = 2'd3
    } cbf_state_e;

    // Total BM reads for one command: words per round times rounds.
    function automatic logic [CBF_TOTAL_W-1:0] cbf_total_reads(
        input logic [CBF_CNT_W-1:0] nw,
        input logic [CBF_CNT_W-1:0] nr
    );
        return CBF_TOTAL_W'(nw) * CBF_TOTAL_W'(nr);
    endfunction

endpackage

// File: rtl/conv_bias_fetch_if.sv
// Bias memory read port plus valid/ready bias stream towards the conv output stage.
interface conv_bias_fetch_if
    import conv_bias_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = CBF_ADDR_W,
    parameter int unsigned DATA_W = CBF_DATA_W
);
    logic              bm_rd_en;
    logic [ADDR_W-1:0] bm_rd_addr;
    logic [DATA_W-1:0] bm_dout;
    logic              bm_dout_vld;
    logic [DATA_W-1:0] bias_data;
    logic              bias_valid;
    logic              bias_ready;

    modport master (
        output bm_rd_en, bm_rd_addr,
        input  bm_dout, bm_dout_vld,
        output bias_data, bias_valid,
        input  bias_ready
    );

    modport slave (
        input  bm_rd_en, bm_rd_addr,
        output bm_dout, bm_dout_vld,
        input  bias_data, bias_valid,
        output bias_ready
    );
endinterface

// File: rtl/conv_bias_fifo.sv
// Skid FIFO absorbing BM read latency; head word and flags come straight from registers.
module conv_bias_fifo #(
    parameter int unsigned WIDTH = 512,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, empty_q;
    logic             do_wr, do_rd;

    // A read in the same cycle frees the slot, so a write into a full FIFO still lands.
    assign do_rd = rd_en_i && !empty_q;
    assign do_wr = wr_en_i && (!full_q || do_rd);

    always_comb begin
        count_d = count_q;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign full_o    = full_q;
    assign empty_o   = empty_q;
endmodule

// File: rtl/conv_bias_fetch.sv
// Credit-limited sequential bias fetch from BM with range replay, feeding a valid/ready stream.
module conv_bias_fetch
    import conv_bias_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W     = CBF_ADDR_W,
    parameter int unsigned DATA_W     = CBF_DATA_W,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned RD_LAT     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_pulse,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [CBF_CNT_W-1:0] n_words,
    input  logic [CBF_CNT_W-1:0] n_rounds,
    output logic                 busy,
    output logic                 done_pulse,
    conv_bias_fetch_if.master    bus
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CRD_W = CNT_W + 1;

    if (FIFO_DEPTH < RD_LAT + 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("conv_bias_fetch: FIFO_DEPTH must be a power of two and >= RD_LAT+2");
    end

    cbf_state_e             state_q, state_d;
    logic [ADDR_W-1:0]      base_q, base_d;
    logic [CBF_CNT_W-1:0]   nwords_q, nwords_d;
    logic [CBF_CNT_W-1:0]   word_idx_q, word_idx_d;
    logic [CBF_TOTAL_W-1:0] rd_left_q, rd_left_d;
    logic [CBF_TOTAL_W-1:0] out_left_q, out_left_d;
    logic [CNT_W-1:0]       outst_q, outst_d;
    logic                   rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]      rd_addr_q, rd_addr_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_full, fifo_empty;
    logic                   rsp_ok, fifo_wr, fifo_rd, credit_ok;

    // Orphan responses (no read outstanding) and anything arriving in IDLE are dropped.
    assign rsp_ok    = bus.bm_dout_vld && (outst_q != '0);
    assign fifo_wr   = rsp_ok && (state_q != CBF_IDLE);
    assign fifo_rd   = bus.bias_valid && bus.bias_ready;
    assign credit_ok = (CRD_W'(outst_q) + CRD_W'(fifo_count) + CRD_W'(rd_en_q)) < CRD_W'(FIFO_DEPTH);

    conv_bias_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (fifo_wr),
        .wr_data_i (bus.bm_dout),
        .rd_en_i   (fifo_rd),
        .rd_data_o (bus.bias_data),
        .count_o   (fifo_count),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        nwords_d   = nwords_q;
        word_idx_d = word_idx_q;
        rd_left_d  = rd_left_q;
        out_left_d = out_left_q;
        outst_d    = outst_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;

        if (fifo_rd && out_left_q != '0) out_left_d = out_left_q - CBF_TOTAL_W'(1);

        case ({rd_en_q, rsp_ok})
            2'b10:   outst_d = outst_q + CNT_W'(1);
            2'b01:   outst_d = outst_q - CNT_W'(1);
            default: outst_d = outst_q;
        endcase

        case (state_q)
            CBF_IDLE: begin
                if (start_pulse) begin
                    base_d     = base_addr;
                    nwords_d   = n_words;
                    word_idx_d = '0;
                    rd_left_d  = cbf_total_reads(n_words, n_rounds);
                    out_left_d = cbf_total_reads(n_words, n_rounds);
                    state_d    = (n_words == '0 || n_rounds == '0) ? CBF_DONE : CBF_RUN;
                end
            end
            CBF_RUN: begin
                if (credit_ok) begin
                    rd_en_d    = 1'b1;
                    rd_addr_d  = base_q + ADDR_W'(word_idx_q);
                    word_idx_d = (word_idx_q == nwords_q - CBF_CNT_W'(1)) ? '0
                                                                         : word_idx_q + CBF_CNT_W'(1);
                    rd_left_d  = rd_left_q - CBF_TOTAL_W'(1);
                    if (rd_left_q == CBF_TOTAL_W'(1)) state_d = CBF_DRAIN;
                end
            end
            // Leave as soon as the final handshake is under way so done follows it by one cycle.
            CBF_DRAIN: begin
                if (out_left_d == '0 && outst_d == '0) state_d = CBF_DONE;
            end
            CBF_DONE: state_d = CBF_IDLE;
            default:  state_d = CBF_IDLE;
        endcase

        busy_d = (state_d != CBF_IDLE);
        done_d = (state_d == CBF_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CBF_IDLE;
            base_q     <= '0;
            nwords_q   <= '0;
            word_idx_q <= '0;
            rd_left_q  <= '0;
            out_left_q <= '0;
            outst_q    <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            nwords_q   <= nwords_d;
            word_idx_q <= word_idx_d;
            rd_left_q  <= rd_left_d;
            out_left_q <= out_left_d;
            outst_q    <= outst_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.bm_rd_en   = rd_en_q;
    assign bus.bm_rd_addr = rd_addr_q;
    assign bus.bias_valid = !fifo_empty;
    assign busy           = busy_q;
    assign done_pulse     = done_q;

    ap_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.bm_dout_vld && state_q != CBF_IDLE) |-> (outst_q != '0));

    ap_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_wr |-> (!fifo_full || fifo_rd));
endmodule

// File: doc/conv_bias_fetch.md
Name: conv_bias_fetch

Overview:
- Streams bias words from the Bias Memory conv read port (rd_en_conv / rd_addr_conv / dout_conv / dout_vld_conv) into the conv output stage.
- The conv output stage is the downstream consumer and uses a valid/ready handshake.
- Issues credit-limited sequential reads, absorbs the fixed BM read latency in a small skid FIFO, and can replay the same bias range for several spatial tiles.
- Sits between bm and the conv requantisation/accumulate stage.

Parameters:
- ADDR_W, 10, bias memory address width (= clog2 of BM depth).
- DATA_W, 512, bias word width (= BM data width).
- FIFO_DEPTH, 8, skid FIFO entries, power of two, must be >= RD_LAT+2.
- RD_LAT, 2, cycles from rd_en to dout_vld in BM.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start_pulse  in  1  one-cycle command strobe.
- base_addr  in  ADDR_W  first bias word address.
- n_words  in  16  words per round.
- n_rounds  in  16  number of times the range is replayed.
- busy  out  1  high from accepted start until done_pulse inclusive.
- done_pulse  out  1  one cycle, after the last word is handshaken out.
- bm_rd_en  out  1  drives rd_en_conv.
- bm_rd_addr  out  ADDR_W  drives rd_addr_conv.
- bm_dout  in  DATA_W  from dout_conv.
- bm_dout_vld  in  1  from dout_vld_conv.
- bias_data  out  DATA_W  FIFO head.
- bias_valid  out  1  FIFO non-empty.
- bias_ready  in  1  consumer accept.

Behaviour:
- Reset (async, rst_n low): FSM=IDLE; all counters 0; FIFO empty. Outputs: busy=0, done_pulse=0, bm_rd_en=0, bm_rd_addr=0, bias_valid=0, bias_data=0.
- Reset mid-operation: everything is dropped immediately. In-flight BM responses arriving after reset release while in IDLE are discarded and are never written to the FIFO.
- Command capture: start_pulse in IDLE latches base_addr, n_words and n_rounds. start_pulse outside IDLE is ignored.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start_pulse with n_words!=0 and n_rounds!=0.
  - IDLE -> DONE on start_pulse with either count zero. No reads are issued; done_pulse occurs in the cycle after start.
  - RUN -> DRAIN in the cycle after the final read issue.
  - DRAIN -> DONE when outstanding==0, FIFO is empty, and the last word has been handshaken.
  - DONE -> IDLE after one cycle; done_pulse=1 only in DONE.
- Read issue (RUN): bm_rd_en=1 when credits allow, i.e. outstanding + fifo_count + bm_rd_en_in_flight < FIFO_DEPTH. This guarantees the FIFO never overflows. bm_rd_en and bm_rd_addr are registered.
- Addressing: bm_rd_addr = base_addr + word_idx, modulo 2^ADDR_W (wrap-around is legal, no error).
- Counters:
  - word_idx counts 0..n_words-1, then resets to 0 and round_idx increments.
  - The last read is issued at word_idx=n_words-1, round_idx=n_rounds-1.
  - Total reads = n_words*n_rounds, held in a 32-bit counter.
- outstanding counter: +1 on bm_rd_en, -1 on bm_dout_vld, net 0 when both occur in the same cycle. Its width is clog2(FIFO_DEPTH)+1.
- FIFO write: bm_dout_vld while not IDLE.
- FIFO read: bias_valid & bias_ready.
- Simultaneous FIFO write and read when full: the read side frees the entry and the write succeeds; count is unchanged. The credit rule makes this case unreachable in normal use, but it must still be handled correctly.
- Output latency: the first bias_valid occurs RD_LAT+1 cycles after the first bm_rd_en (registered FIFO output).
- Throughput:
  - With bias_ready held high, one word per cycle is sustained once the pipeline is full.
  - When bias_ready is low, bias_data and bias_valid hold stable until accepted. bias_valid never drops without a handshake.
- Ordering: words are delivered strictly in issue order.
- BM protocol: bm_dout_vld without a matching outstanding read is a protocol error. Such responses are dropped and are covered by a simulation assertion.

Decomposition:
- Shared package (incl.vh macros):
  - BM_DEPTH / BM_DATA_WIDTH feed ADDR_W / DATA_W.
  - FSM state encodings CBF_IDLE/RUN/DRAIN/DONE.
- One sub-module: conv_bias_fifo, a synchronous FIFO with registered output, parameters WIDTH/DEPTH, and outputs count, full and empty. It uses the same clk/rst_n.
- The FSM, counters and credit logic stay in conv_bias_fetch.

Test Plan:
- Basic run: base=0x010, n_words=4, n_rounds=1, ready=1 → reads to 0x010..0x013 on 4 consecutive cycles; bias_data equals mem[0x010..0x013] in order; done_pulse 1 cycle after the 4th handshake; busy low the next cycle.
- Replay with wrap: base=0x3FE, n_words=3, n_rounds=2 → address sequence 0x3FE, 0x3FF, 0x000, 0x3FE, 0x3FF, 0x000; 6 words out.
- Backpressure: n_words=32, bias_ready low for 20 cycles after the first valid → at most FIFO_DEPTH (8) reads outstanding or buffered; no word is lost or duplicated; data stays stable while stalled; all 32 words arrive after ready rises.
- Zero count: start with n_words=0 → no bm_rd_en; done_pulse exactly 1 cycle after start. Repeat with n_rounds=0 → same response.
- Start while busy: a second start_pulse mid-run with different base → ignored; the original sequence completes unchanged.
- Async reset mid-run: rst_n low for 1 cycle after 5 reads with 2 in flight → all outputs return to reset values immediately; late bm_dout_vld responses are discarded; a new command then runs cleanly.
